text_pixel_gen: RTL and testbench
=================================

Name: text_pixel_gen

Overview:
- Upstream stage of the CGA colour block: converts VGA raster coordinates into a per-pixel 8-bit CGA attribute (irgb back, irgb fore) plus the foreground-select bit.
- Reads an 80x30 character/attribute video RAM and an 8x16 font ROM, both synchronous, one-cycle read latency.
- Adds attribute blink and a blinking underline cursor.
- Delays de/hsync/vsync so they stay aligned with the pixel data.

Parameters:
- COLS, 80, text columns per row (col = x[9:3]).
- ROWS, 30, text rows (row = y[9:4]).
- ADDR_W, 12, video RAM address width; must hold COLS*ROWS-1.
- BLINK_EN, 1, 1 = attr bit 7 is blink, 0 = bit 7 is background intensity.

Ports:
- i_clk  in  1  pixel clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_x  in  10  current pixel column from timing generator.
- i_y  in  10  current pixel line.
- i_de  in  1  active video.
- i_hsync  in  1  horizontal sync, passed through.
- i_vsync  in  1  vertical sync, active-high, passed through.
- i_cursor_col  in  7  cursor text column.
- i_cursor_row  in  5  cursor text row.
- i_cursor_en  in  1  cursor enable.
- o_vram_addr  out  ADDR_W  video RAM read address (combinational).
- i_vram_data  in  16  {attr[15:8], char[7:0]}, valid one clock after address.
- o_font_addr  out  12  font ROM address {char, line[3:0]} (combinational).
- i_font_data  in  8  glyph row, bit 7 = leftmost pixel, valid one clock after address.
- o_attr  out  8  CGA attribute to the colour stage.
- o_fg  out  1  1 = foreground colour, 0 = background colour.
- o_de  out  1  delayed de.
- o_hsync  out  1  delayed hsync.
- o_vsync  out  1  delayed vsync.

Behaviour:
- Reset (i_rstn low, async): all pipeline registers, outputs and the frame counter go to 0. o_attr=0, o_fg=0, o_de=0, o_hsync=0, o_vsync=0.
- Cycle t (inputs valid): o_vram_addr = i_y[9:4]*COLS + i_x[9:3], truncated to ADDR_W. Coordinates outside the text area are don't-care, masked by de.
- Stage 1 register (t+1): captures x[2:0], y[3:0], col, row, de, hsync, vsync.
  - o_font_addr = {i_vram_data[7:0], stage1 y[3:0]}.
  - Stage 2 register latches i_vram_data[15:8] as attr.
- Stage 2 register (t+2): holds attr, x[2:0], cursor-hit flag, line, syncs and de.
  - pix = i_font_data[7 - x[2:0]].
- Output register (t+3): fixed latency of 3 clocks for every output. No stalls.
- Attribute handling:
  - BLINK_EN=1: attr bit 7 is the blink flag. The attr sent out has bit 7 cleared (background limited to 8 colours). When blink=1 and blink phase is off, pix is forced to 0.
  - BLINK_EN=0: attr passes unchanged.
- Cursor:
  - Hit when i_cursor_en=1, col==i_cursor_col, row==i_cursor_row, line in {14,15} and cursor phase=1.
  - On a hit, fg = ~pix.
  - Cursor is evaluated after blink masking.
- Frame counter: 5-bit, increments on each i_vsync rising edge (0->1 seen between consecutive clocks), wraps 31->0.
  - Cursor phase = cnt[3] (toggles every 8 frames).
  - Blink phase on = cnt[4] (toggles every 16 frames).
- Blanking: when delayed de=0, o_attr=0 and o_fg=0; syncs still pass through.
- Reset mid-frame: pipeline and counter clear. The first valid output appears 3 clocks after i_rstn releases.

Test Plan:
- Reset: hold i_rstn=0, drive i_de=1 with random data -> all outputs 0. Release; vsync pulse injected at t emerges on o_vsync at t+3.
- Address: i_x=17, i_y=35, COLS=80 -> o_vram_addr=2*80+2=162 the same cycle. Return vram {8'h1E,8'h41} next clock -> o_font_addr=12'h413 (y[3:0]=3).
- Pixel select: attr 8'h1E, font data 8'b1000_0001, x[2:0] sweeping 0..7 -> o_fg=1,0,0,0,0,0,0,1 with o_attr=8'h1E, each 3 clocks after its input.
- Blink: BLINK_EN=1, attr 8'h9F, font 8'hFF.
  - Frame counter 0..15 -> o_attr=8'h1F, o_fg=0.
  - After 16 vsync edges -> o_fg=1.
  - After 32 edges the counter wraps and o_fg=0 again.
- Cursor: i_cursor_en=1, cursor (5,2), font 8'h00, counter=8 -> lines y=46,47 at x=40..47 give o_fg=1. Line y=45 gives 0. Counter=0 gives 0. i_cursor_en=0 gives 0.
- Blanking: i_de=0 with nonzero vram/font data -> o_de=0, o_attr=0, o_fg=0 at t+3; o_hsync follows i_hsync.

Source files
------------

// File: rtl/text_pixel_gen.sv
// text_pixel_gen
// Converts VGA raster coordinates into a per-pixel CGA attribute and a
// foreground-select bit. A text cell is 8x16 pixels. Character and attribute
// come from a synchronous video RAM and the glyph row from a synchronous font
// ROM, each with one clock of read latency. Attribute blink and a blinking
// underline cursor are applied after the glyph lookup. Every output, including
// the passed-through de/hsync/vsync, has a fixed latency of 3 clocks.
//
// Pipeline, for a coordinate presented in cycle t:
//   t   : VRAM address is formed combinationally from the coordinates.
//   t+1 : stage 1 holds the cell coordinates; VRAM data is valid and forms
//         the font address.
//   t+2 : stage 2 holds the attribute and the cursor hit; font data is valid
//         and the pixel bit is selected.
//   t+3 : output registers hold the result.
module text_pixel_gen #(
    parameter int COLS     = 80,
    parameter int ROWS     = 30,
    parameter int ADDR_W   = 12,
    parameter bit BLINK_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    input  logic              i_de,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic [6:0]        i_cursor_col,
    input  logic [4:0]        i_cursor_row,
    input  logic              i_cursor_en,
    output logic [ADDR_W-1:0] o_vram_addr,
    input  logic [15:0]       i_vram_data,
    output logic [11:0]       o_font_addr,
    input  logic [7:0]        i_font_data,
    output logic [7:0]        o_attr,
    output logic              o_fg,
    output logic              o_de,
    output logic              o_hsync,
    output logic              o_vsync
);

    localparam logic [ADDR_W-1:0] COLS_W = ADDR_W'(COLS);
    localparam logic [5:0]        ROWS_W = 6'(ROWS);

    // Stage 1: cell coordinates and syncs, aligned with VRAM read data.
    logic [2:0] s1_xpix_q;
    logic [3:0] s1_line_q;
    logic [6:0] s1_col_q;
    logic [5:0] s1_row_q;
    logic       s1_de_q;
    logic       s1_hsync_q;
    logic       s1_vsync_q;

    // Stage 2: attribute and cursor hit, aligned with font ROM read data.
    logic [7:0] s2_attr_q;
    logic [2:0] s2_xpix_q;
    logic       s2_hit_q;
    logic       s2_hit_d;
    logic       s2_de_q;
    logic       s2_hsync_q;
    logic       s2_vsync_q;

    // Output registers.
    logic [7:0] attr_q;
    logic [7:0] attr_d;
    logic       fg_q;
    logic       fg_d;
    logic       de_q;
    logic       hsync_q;
    logic       vsync_q;

    // Frame counter: bit 3 is the cursor phase, bit 4 the blink phase.
    logic       vsync_prev_q;
    logic [4:0] frame_cnt_q;
    logic [4:0] frame_cnt_d;

    logic       cursor_phase;
    logic       blink_on;
    logic       pix;
    logic       blink_mask;
    logic       pix_vis;

    // Row-major cell address; wraps at ADDR_W for coordinates outside the
    // text area, which are blanked by de anyway.
    assign o_vram_addr = ADDR_W'(i_y[9:4]) * COLS_W + ADDR_W'(i_x[9:3]);

    // Glyph row address: character code from VRAM, line within the cell.
    assign o_font_addr = {i_vram_data[7:0], s1_line_q};

    assign cursor_phase = frame_cnt_q[3];
    assign blink_on     = frame_cnt_q[4];

    // Glyph bit 7 is the leftmost pixel of the cell.
    assign pix        = i_font_data[3'd7 - s2_xpix_q];
    assign blink_mask = BLINK_EN && s2_attr_q[7] && !blink_on;
    assign pix_vis    = pix && !blink_mask;

    // Count vsync rising edges seen between consecutive clocks; wraps 31->0.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (i_vsync && !vsync_prev_q) begin
            frame_cnt_d = frame_cnt_q + 5'd1;
        end
    end

    // Cursor covers the bottom two lines of its cell while the phase is on.
    // Rows beyond the text area never show a cursor.
    always_comb begin
        s2_hit_d = i_cursor_en
                && (s1_col_q == i_cursor_col)
                && (s1_row_q == {1'b0, i_cursor_row})
                && (s1_row_q < ROWS_W)
                && (s1_line_q[3:1] == 3'b111)
                && cursor_phase;
    end

    // Final colour selection: blink masks the glyph first, the cursor then
    // inverts it; blanking forces attribute and fg to zero.
    always_comb begin
        attr_d = '0;
        fg_d   = 1'b0;
        if (s2_de_q) begin
            attr_d = BLINK_EN ? {1'b0, s2_attr_q[6:0]} : s2_attr_q;
            fg_d   = s2_hit_q ? !pix_vis : pix_vis;
        end
    end

    // Frame counter and vsync edge history.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vsync_prev_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            vsync_prev_q <= i_vsync;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Stage 1: capture coordinates and syncs while VRAM is being read.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_xpix_q  <= '0;
            s1_line_q  <= '0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_de_q    <= 1'b0;
            s1_hsync_q <= 1'b0;
            s1_vsync_q <= 1'b0;
        end else begin
            s1_xpix_q  <= i_x[2:0];
            s1_line_q  <= i_y[3:0];
            s1_col_q   <= i_x[9:3];
            s1_row_q   <= i_y[9:4];
            s1_de_q    <= i_de;
            s1_hsync_q <= i_hsync;
            s1_vsync_q <= i_vsync;
        end
    end

    // Stage 2: latch attribute and cursor hit while the font ROM is read.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s2_attr_q  <= '0;
            s2_xpix_q  <= '0;
            s2_hit_q   <= 1'b0;
            s2_de_q    <= 1'b0;
            s2_hsync_q <= 1'b0;
            s2_vsync_q <= 1'b0;
        end else begin
            s2_attr_q  <= i_vram_data[15:8];
            s2_xpix_q  <= s1_xpix_q;
            s2_hit_q   <= s2_hit_d;
            s2_de_q    <= s1_de_q;
            s2_hsync_q <= s1_hsync_q;
            s2_vsync_q <= s1_vsync_q;
        end
    end

    // Output stage: register the final pixel decision and delayed syncs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            attr_q  <= '0;
            fg_q    <= 1'b0;
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            attr_q  <= attr_d;
            fg_q    <= fg_d;
            de_q    <= s2_de_q;
            hsync_q <= s2_hsync_q;
            vsync_q <= s2_vsync_q;
        end
    end

    assign o_attr  = attr_q;
    assign o_fg    = fg_q;
    assign o_de    = de_q;
    assign o_hsync = hsync_q;
    assign o_vsync = vsync_q;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Testbench for text_pixel_gen: models VRAM and font ROM as arrays with one
// clock of read latency and predicts each output from the cell/glyph rules.
module tb_text_pixel_gen;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic [9:0]  i_x = '0;
    logic [9:0]  i_y = '0;
    logic        i_de = 1'b0;
    logic        i_hsync = 1'b0;
    logic        i_vsync = 1'b0;
    logic [6:0]  cur_col = '0;
    logic [4:0]  cur_row = '0;
    logic        cur_en = 1'b0;
    logic [11:0] vram_addr;
    logic [11:0] font_addr;
    logic [15:0] vram_data = '0;
    logic [7:0]  font_data = '0;
    logic [7:0]  o_attr;
    logic        o_fg;
    logic        o_de;
    logic        o_hsync;
    logic        o_vsync;

    logic [15:0] vram [0:4095];
    logic [7:0]  font [0:4095];

    typedef struct {
        logic [7:0] attr;
        logic       fg;
        logic       de;
        logic       hs;
        logic       vs;
    } pout_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic [7:0] attr;
        logic       fg;
    } vec_t;

    int     n_vec = 0;
    int     n_err = 0;
    int     cnt_m = 0;
    logic   vs_prev_m = 1'b0;
    pout_t  expq[$];
    string  tagq[$];
    vec_t   tab[12];

    text_pixel_gen dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_x          (i_x),
        .i_y          (i_y),
        .i_de         (i_de),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .i_cursor_col (cur_col),
        .i_cursor_row (cur_row),
        .i_cursor_en  (cur_en),
        .o_vram_addr  (vram_addr),
        .i_vram_data  (vram_data),
        .o_font_addr  (font_addr),
        .i_font_data  (font_data),
        .o_attr       (o_attr),
        .o_fg         (o_fg),
        .o_de         (o_de),
        .o_hsync      (o_hsync),
        .o_vsync      (o_vsync)
    );

    always #5 clk = ~clk;

    // Synchronous memories with one clock of read latency.
    always @(posedge clk) begin
        vram_data <= vram[vram_addr];
        font_data <= font[font_addr];
    end

    // Expected output for a coordinate, from the text-mode rules.
    function automatic pout_t model(input logic [9:0] x, input logic [9:0] y,
                                    input logic de, input logic hs, input logic vs);
        pout_t      r;
        int         col, row, line, addr;
        logic [15:0] w;
        logic [7:0]  g, at;
        logic        pix, hit;
        r.de = de; r.hs = hs; r.vs = vs; r.attr = '0; r.fg = 1'b0;
        if (de) begin
            col  = int'(x) / 8;
            row  = int'(y) / 16;
            line = int'(y) % 16;
            addr = (row * 80 + col) % 4096;
            w    = vram[addr];
            at   = w[15:8];
            g    = font[int'(w[7:0]) * 16 + line];
            pix  = g[7 - (int'(x) % 8)];
            if (at[7] && cnt_m < 16) pix = 1'b0;
            hit  = cur_en && (col == int'(cur_col)) && (row == int'(cur_row))
                   && (line >= 14) && ((cnt_m % 16) >= 8);
            r.fg   = pix ^ hit;
            r.attr = {1'b0, at[6:0]};
        end
        return r;
    endfunction

    task automatic check_out(input string tag, input pout_t e);
        n_vec++;
        if ({o_attr, o_fg, o_de, o_hsync, o_vsync} !== {e.attr, e.fg, e.de, e.hs, e.vs}) begin
            n_err++;
            $display("FAIL %s: got attr=%h fg=%b de=%b hs=%b vs=%b, expected attr=%h fg=%b de=%b hs=%b vs=%b",
                     tag, o_attr, o_fg, o_de, o_hsync, o_vsync, e.attr, e.fg, e.de, e.hs, e.vs);
        end
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if ({o_attr, o_fg, o_de, o_hsync, o_vsync} !== 12'h000) begin
            n_err++;
            $display("FAIL %s: got attr=%h fg=%b de=%b hs=%b vs=%b, expected all zero",
                     tag, o_attr, o_fg, o_de, o_hsync, o_vsync);
        end
    endtask

    // One pixel clock: drive, check the address paths, and compare the output
    // of the coordinate presented three clocks earlier.
    task automatic cycle(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic de, input logic hs, input logic vs,
                         input logic use_tab, input logic [7:0] t_attr, input logic t_fg);
        pout_t       e;
        int          addr;
        logic [11:0] faddr;
        i_x = x; i_y = y; i_de = de; i_hsync = hs; i_vsync = vs;
        if (vs && !vs_prev_m) cnt_m = (cnt_m + 1) % 32;
        vs_prev_m = vs;
        e = model(x, y, de, hs, vs);
        if (use_tab) begin
            e.attr = t_attr;
            e.fg   = t_fg;
        end
        addr  = ((int'(y) / 16) * 80 + int'(x) / 8) % 4096;
        faddr = {vram[addr][7:0], y[3:0]};
        #1;
        n_vec++;
        if (vram_addr !== 12'(addr)) begin
            n_err++;
            $display("FAIL vram_addr(%s): got %0d, expected %0d", tag, vram_addr, addr);
        end
        expq.push_back(e);
        tagq.push_back(tag);
        @(posedge clk);
        #1;
        n_vec++;
        if (font_addr !== faddr) begin
            n_err++;
            $display("FAIL font_addr(%s): got %h, expected %h", tag, font_addr, faddr);
        end
        if (expq.size() == 3) check_out(tagq.pop_front(), expq.pop_front());
    endtask

    task automatic blanks(input int n);
        for (int i = 0; i < n; i++) cycle("blank", 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic pulse_vs(input int n);
        for (int i = 0; i < n; i++) begin
            cycle("vs_hi", 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            cycle("vs_lo", 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        blanks(3);
    endtask

    // Assert reset asynchronously, hold it with live active-video input, then
    // release. The two register stages behind the output must deliver zeros.
    task automatic do_reset(input int n);
        pout_t z;
        rstn = 1'b0;
        #1;
        check_zero("rst_async");
        for (int i = 0; i < n; i++) begin
            i_x = 10'($urandom_range(639));
            i_y = 10'($urandom_range(479));
            i_de = 1'b1;
            i_hsync = 1'($urandom);
            i_vsync = 1'($urandom);
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        i_de = 1'b0; i_vsync = 1'b0; i_hsync = 1'b0;
        expq.delete();
        tagq.delete();
        cnt_m = 0;
        vs_prev_m = 1'b0;
        z.attr = '0; z.fg = 1'b0; z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b0;
        expq.push_back(z); tagq.push_back("post_rst");
        expq.push_back(z); tagq.push_back("post_rst");
        rstn = 1'b1;
    endtask

    initial begin
        logic [7:0] sweep_fg;
        logic [9:0] rx, ry;
        sweep_fg = 8'b1000_0001;

        for (int i = 0; i < 4096; i++) begin
            vram[i] = 16'($urandom);
            font[i] = 8'($urandom);
        end
        vram[0]   = 16'h1E05;   font[5*16 + 0] = 8'b1000_0001;
        vram[162] = 16'h1E41;
        vram[81]  = 16'h9F10;   font[16'h10*16 + 0] = 8'hFF;
        vram[165] = 16'h0720;
        font[16'h20*16 + 13] = 8'h00;
        font[16'h20*16 + 14] = 8'h00;
        font[16'h20*16 + 15] = 8'h00;

        for (int i = 0; i < 8; i++)
            tab[i] = '{x: 10'(i), y: 10'd0, de: 1'b1, hs: 1'b0, attr: 8'h1E, fg: sweep_fg[7-i]};
        for (int i = 8; i < 11; i++)
            tab[i] = '{x: 10'(i - 8), y: 10'd0, de: 1'b0, hs: 1'b1, attr: 8'h00, fg: 1'b0};
        tab[11] = '{x: 10'd8, y: 10'd16, de: 1'b1, hs: 1'b0, attr: 8'h1F, fg: 1'b0};

        #2;
        do_reset(4);

        // Sync pass-through latency right after reset.
        cycle("vs_pre", 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle("vs_pulse", 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle("vs_post", 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        blanks(3);

        // Address formation for x=17, y=35.
        cycle("addr", 10'd17, 10'd35, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (vram_addr !== 12'd162) begin
            n_err++;
            $display("FAIL addr_162: got %0d, expected 162", vram_addr);
        end
        n_vec++;
        if (font_addr !== 12'h413) begin
            n_err++;
            $display("FAIL faddr_413: got %h, expected 413", font_addr);
        end

        // Table: pixel select sweep, blanking with live data, blink (cnt=1).
        for (int i = 0; i < 12; i++)
            cycle($sformatf("tab%0d", i), tab[i].x, tab[i].y, tab[i].de, tab[i].hs, 1'b0,
                  1'b1, tab[i].attr, tab[i].fg);
        cycle("tab_tail", 10'd3, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset in the middle of a busy pipeline clears counter and stages.
        do_reset(3);
        cur_col = 7'd5; cur_row = 5'd2; cur_en = 1'b1;
        blanks(1);

        cycle("blink_c0", 10'd8, 10'd16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b0);
        cycle("cur_c0", 10'd40, 10'd46, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0);
        pulse_vs(8);
        cycle("blink_c8", 10'd8, 10'd16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b0);
        for (int x = 40; x < 48; x++) begin
            cycle("cur_l14", 10'(x), 10'd46, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1);
            cycle("cur_l15", 10'(x), 10'd47, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1);
        end
        cycle("cur_l13", 10'd43, 10'd45, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0);
        blanks(1);
        cur_en = 1'b0;
        blanks(1);
        cycle("cur_dis", 10'd40, 10'd46, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0);
        blanks(1);
        cur_en = 1'b1;
        pulse_vs(8);
        cycle("blink_c16", 10'd8, 10'd16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b1);
        cycle("cur_c16", 10'd40, 10'd46, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0);
        pulse_vs(16);
        cycle("blink_wrap", 10'd8, 10'd16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b0);
        cycle("cur_wrap", 10'd40, 10'd46, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0);
        blanks(1);

        // Random frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            cur_en  = 1'($urandom_range(1));
            cur_col = 7'($urandom_range(79));
            cur_row = 5'($urandom_range(29));
            pulse_vs($urandom_range(5));
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(3) == 0) begin
                    rx = 10'(int'(cur_col) * 8 + $urandom_range(7));
                    ry = 10'(int'(cur_row) * 16 + 14 + $urandom_range(1));
                end else begin
                    rx = 10'($urandom_range(639));
                    ry = 10'($urandom_range(479));
                end
                cycle("rand", rx, ry, ($urandom_range(7) != 0), 1'($urandom), 1'b0,
                      1'b0, 8'h00, 1'b0);
            end
            blanks(1);
        end
        blanks(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
